// File: rtl/delayed_and_pkg.sv
// Shared types and helpers for the delayed AND producer stage.
package delayed_and_pkg;

  // Lifecycle of one buffer slot.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAITING = 2'd1,
    RIPE    = 2'd2
  } slot_state_e;

  // Width of the saturating stall counter.
  localparam int STALL_W = 16;

  // Slot countdown width: enough bits to hold DELAY-1, never less than one.
  function automatic int cnt_width(input int delay);
    int w;
    w = $clog2(delay);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/delayed_and_stage_slot.sv
// One buffer slot: holds a result and counts down until it may be presented.
module delay_slot
  import delayed_and_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DELAY = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             ripe,
  output logic [WIDTH-1:0] data_out
);

  localparam int CW = cnt_width(DELAY);

  slot_state_e      state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] data_r;

  // Slot FSM: capture on load, count down while waiting, release on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      cnt_r   <= '0;
      data_r  <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (load) begin
            data_r  <= data_in;
            cnt_r   <= CW'(DELAY - 1);
            // A single-cycle delay is ripe straight after capture.
            state_r <= (DELAY == 1) ? RIPE : WAITING;
          end else begin
            state_r <= EMPTY;
          end
        end
        WAITING: begin
          // Reaching zero on this edge makes the result presentable.
          if (cnt_r <= CW'(1)) begin
            cnt_r   <= '0;
            state_r <= RIPE;
          end else begin
            cnt_r   <= cnt_r - CW'(1);
          end
        end
        RIPE: begin
          if (pop) begin
            state_r <= EMPTY;
          end else begin
            state_r <= RIPE;
          end
        end
        default: begin
          state_r <= EMPTY;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign ripe     = (state_r == RIPE);
  assign data_out = data_r;

endmodule

// File: rtl/delayed_and_stage.sv
// Delayed AND producer: each accepted pair yields a & b exactly DELAY cycles later.
module delayed_and_stage
  import delayed_and_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DELAY = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_w,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [OW-1:0]      count_r;
  logic [STALL_W-1:0] stall_cnt_r;

  logic               full_s;
  logic               accept_s;
  logic               pop_s;
  logic               out_valid_s;
  logic [WIDTH-1:0]   out_w_s;
  logic [WIDTH-1:0]   and_s;
  logic [DEPTH-1:0]   load_s;
  logic [DEPTH-1:0]   pop_vec_s;
  logic [DEPTH-1:0]   ripe_s;
  logic [WIDTH-1:0]   slot_data_s [DEPTH];

  // Readiness depends only on the occupancy register, never on out_ready.
  assign full_s      = (count_r == OW'(DEPTH));
  assign accept_s    = in_valid && !full_s;
  assign out_valid_s = ripe_s[rd_ptr_r];
  assign pop_s       = out_valid_s && out_ready;
  assign and_s       = in_a & in_b;

  // Steer load to the write slot and pop to the read slot.
  always_comb begin
    load_s    = '0;
    pop_vec_s = '0;
    if (accept_s) begin
      load_s[wr_ptr_r] = 1'b1;
    end else begin
      load_s = '0;
    end
    if (pop_s) begin
      pop_vec_s[rd_ptr_r] = 1'b1;
    end else begin
      pop_vec_s = '0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    delay_slot #(
      .WIDTH (WIDTH),
      .DELAY (DELAY)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s[i]),
      .data_in  (and_s),
      .pop      (pop_vec_s[i]),
      .ripe     (ripe_s[i]),
      .data_out (slot_data_s[i])
    );
  end

  // Head result is forced to zero whenever nothing is presentable.
  always_comb begin
    out_w_s = '0;
    if (out_valid_s) begin
      out_w_s = slot_data_s[rd_ptr_r];
    end else begin
      out_w_s = '0;
    end
  end

  // Pointer and occupancy bookkeeping; accept+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + OW'(1);
        2'b01:   count_r <= count_r - OW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of cycles where a ripe head is back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (out_valid_s && !out_ready && (stall_cnt_r != {STALL_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + STALL_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = !full_s;
  assign out_valid = out_valid_s;
  assign out_w     = out_w_s;
  assign occupancy = count_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_delayed_and_stage.sv
// Directed bench for delayed_and_stage: a DELAY=10 build and a DELAY=1 build.
module tb_delayed_and_stage;

  logic        clk;
  logic        rst_n;

  // DELAY=10, DEPTH=4 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_a, in_b, out_w;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  // DELAY=1, DEPTH=2 instance
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  in_a1, in_b1, out_w1;
  logic [1:0]  occupancy1;
  logic [15:0] stall_cnt1;

  int tests_run;
  int tests_failed;

  delayed_and_stage #(.WIDTH(4), .DELAY(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  delayed_and_stage #(.WIDTH(4), .DELAY(1), .DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_w(out_w1),
    .occupancy(occupancy1), .stall_cnt(stall_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are read at the falling edge, i.e. the value the next rising edge samples.
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = 4'h0; in_b1 = 4'h0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_w !== 4'h0 ||
        occupancy !== 3'd0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset: rdy=%b vld=%b w=%h occ=%0d stall=%0d, expected 1 0 0 0 0",
               in_ready, out_valid, out_w, occupancy, stall_cnt);
    end
    tests_run++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || occupancy1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_d1: rdy=%b vld=%b occ=%0d, expected 1 0 0", in_ready1, out_valid1, occupancy1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One accept: 4'hD & 4'h7 = 4'h5, visible for exactly one sample at edge 10.
  task automatic test_single();
    in_valid = 1'b1; in_a = 4'hD; in_b = 4'h7; out_ready = 1'b1;
    @(negedge clk);             // after accept edge 0
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_occ: got %0d expected 1", occupancy);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_early: out_valid=%b at edge %0d, expected 0", out_valid, i + 1);
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_w !== 4'h5) begin
      tests_failed++;
      $display("FAIL single_ripe: vld=%b w=%h expected 1 5", out_valid, out_w);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_w !== 4'h0 || occupancy !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_after: vld=%b w=%h occ=%0d expected 0 0 0", out_valid, out_w, occupancy);
    end
  endtask

  // Fill all four slots back to back; results drain on consecutive edges.
  task automatic test_fill();
    logic [3:0] va [4] = '{4'hF, 4'hA, 4'hC, 4'h9};
    logic [3:0] vb [4] = '{4'h3, 4'h5, 4'h6, 4'hB};
    logic [3:0] ex [4] = '{4'h3, 4'h0, 4'h4, 4'h9};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
      tests_failed++;
      $display("FAIL fill_full: rdy=%b occ=%0d expected 0 4", in_ready, occupancy);
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_w !== ex[i]) begin
        tests_failed++;
        $display("FAIL fill_out%0d: vld=%b w=%h expected 1 %h", i, out_valid, out_w, ex[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_drained: vld=%b occ=%0d rdy=%b expected 0 0 1", out_valid, occupancy, in_ready);
    end
  endtask

  // Back-pressure the head for 5 edges, then drain everything in order.
  task automatic test_stall();
    logic [3:0] va [4] = '{4'h6, 4'hF, 4'h3, 4'hE};
    logic [3:0] vb [4] = '{4'h7, 4'h8, 4'hC, 4'hB};
    logic [3:0] ex [4] = '{4'h6, 4'h8, 4'h0, 4'hA};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);  // head ripe, sampled at edge 10
    for (int s = 0; s < 5; s++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_w !== ex[0]) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: vld=%b w=%h expected 1 %h", s, out_valid, out_w, ex[0]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (stall_cnt !== 16'd5 || occupancy !== 3'd4) begin
      tests_failed++;
      $display("FAIL stall_cnt: stall=%0d occ=%0d expected 5 4", stall_cnt, occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_w !== ex[i]) begin
        tests_failed++;
        $display("FAIL stall_drain%0d: vld=%b w=%h expected 1 %h", i, out_valid, out_w, ex[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || stall_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL stall_end: vld=%b occ=%0d stall=%0d expected 0 0 5", out_valid, occupancy, stall_cnt);
    end
  endtask

  // Full stage: a pop frees room only for the following edge.
  task automatic test_full_pop();
    logic [3:0] va [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = 4'hF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);  // after edge 9, head ripe
    out_ready = 1'b1; in_valid = 1'b1; in_a = 4'h7; in_b = 4'hD;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpop_rdy0: rdy=%b expected 0", in_ready);
    end
    @(negedge clk);             // edge 10: pop only
    tests_run++;
    if (in_ready !== 1'b1 || occupancy !== 3'd3 || out_w !== 4'h2) begin
      tests_failed++;
      $display("FAIL fullpop_rdy1: rdy=%b occ=%0d w=%h expected 1 3 2", in_ready, occupancy, out_w);
    end
    @(negedge clk);             // edge 11: accept and pop together
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd3 || out_w !== 4'h4) begin
      tests_failed++;
      $display("FAIL fullpop_both: occ=%0d w=%h expected 3 4", occupancy, out_w);
    end
    @(negedge clk);
    tests_run++;
    if (out_w !== 4'h8) begin
      tests_failed++;
      $display("FAIL fullpop_last: w=%h expected 8", out_w);
    end
    @(negedge clk);             // edge 13
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 3'd1) begin
      tests_failed++;
      $display("FAIL fullpop_gap: vld=%b occ=%0d expected 0 1", out_valid, occupancy);
    end
    repeat (7) @(negedge clk);  // edge 20
    tests_run++;
    if (out_valid !== 1'b1 || out_w !== 4'h5) begin
      tests_failed++;
      $display("FAIL fullpop_new: vld=%b w=%h expected 1 5", out_valid, out_w);
    end
    @(negedge clk);
    tests_run++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpop_end: occ=%0d vld=%b expected 0 0", occupancy, out_valid);
    end
  endtask

  // Asynchronous reset with three entries in flight; nothing stale may follow.
  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (7) @(negedge clk);  // head ripe now
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1 ||
        out_w !== 4'h0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_rst: vld=%b occ=%0d rdy=%b w=%h stall=%0d expected 0 0 1 0 0",
               out_valid, occupancy, in_ready, out_w, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
        tests_failed++;
        $display("FAIL async_stale%0d: vld=%b occ=%0d expected 0 0", i, out_valid, occupancy);
      end
    end
  endtask

  // DELAY=1: streaming input gives one result per cycle, one edge later.
  task automatic test_delay1();
    logic [3:0] va [6] = '{4'hF, 4'h3, 4'hA, 4'h6, 4'hC, 4'h9};
    logic [3:0] vb [6] = '{4'h1, 4'h6, 4'hE, 4'h5, 4'hC, 4'h0};
    logic [3:0] ex [6] = '{4'h1, 4'h2, 4'hA, 4'h4, 4'hC, 4'h0};
    out_ready1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid1 = 1'b1; in_a1 = va[i]; in_b1 = vb[i];
      tests_run++;
      if (in_ready1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL d1_ready%0d: rdy=%b expected 1", i, in_ready1);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid1 !== 1'b1 || out_w1 !== ex[i] || occupancy1 !== 2'd1) begin
        tests_failed++;
        $display("FAIL d1_out%0d: vld=%b w=%h occ=%0d expected 1 %h 1",
                 i, out_valid1, out_w1, occupancy1, ex[i]);
      end
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid1 !== 1'b0 || occupancy1 !== 2'd0 || stall_cnt1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL d1_end: vld=%b occ=%0d stall=%0d expected 0 0 0", out_valid1, occupancy1, stall_cnt1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_full_pop();
    test_async_reset();
    test_delay1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
